// File: rtl/wide_addsub_seq_pkg.sv
// Shared constants for the wide add/subtract sequencer: FSM encoding,
// chunk width, and the chunk-index width helper.
package wide_addsub_seq_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the chunk index register; never below one bit.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks <= 2) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/wide_addsub_seq_if.sv
// Start/busy/done handshake bundle between the execute stage and the
// wide add/subtract sequencer.
interface wide_addsub_seq_if #(
    parameter int NUM_CHUNKS = 2
);
    localparam int DW = 16 * NUM_CHUNKS;

    logic          start;
    logic          sub;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          cout;
    logic          ovf;

    modport master (
        output start, sub, op_a, op_b,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output ready, busy, done, result, cout, ovf
    );

endinterface

// File: rtl/wide_addsub_seq_cla.sv
// 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate
// feeding a second lookahead level for the group carries.
import wide_addsub_seq_pkg::*;

module cla_16bit (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        grp_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        // Bit carries inside each group start from the lookahead group carry.
        for (int k = 0; k < 4; k++) begin
            c[4*k] = grp_c[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[16] = grp_c[4];
        sum   = p ^ c[15:0];
        cout  = c[16];
    end

endmodule

// File: rtl/wide_addsub_seq.sv
// Multi-cycle DW-bit add/subtract using one shared 16-bit CLA, one chunk per
// cycle LSB first, with the inter-chunk carry held in a register.
import wide_addsub_seq_pkg::*;

module wide_addsub_seq #(
    parameter int NUM_CHUNKS = 2
) (
    input logic              clk,
    input logic              rst,
    wide_addsub_seq_if.slave bus
);
    localparam int DW = CHUNK_W * NUM_CHUNKS;
    localparam int IW = idx_width(NUM_CHUNKS);

    state_t             state;
    state_t             state_nxt;
    logic [DW-1:0]      a_reg;
    logic [DW-1:0]      b_reg;
    logic [DW-1:0]      result_reg;
    logic [IW-1:0]      idx;
    logic               carry_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] sum;
    logic               chunk_cout;
    logic               last;
    logic               accept;

    assign accept  = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last    = (idx == IW'(NUM_CHUNKS - 1));
    assign a_chunk = a_reg[CHUNK_W*idx +: CHUNK_W];
    assign b_chunk = b_reg[CHUNK_W*idx +: CHUNK_W];

    cla_16bit u_cla (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .sum  (sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (last)   state_nxt = ST_DONE;
            ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == ST_IDLE) || (state == ST_DONE);
        bus.busy  = (state == ST_RUN);
        bus.done  = (state == ST_DONE);
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            idx        <= '0;
        end else if (accept) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.sub;
            idx       <= '0;
        end else if (state == ST_RUN) begin
            result_reg[CHUNK_W*idx +: CHUNK_W] <= sum;
            carry_reg <= chunk_cout;
            idx       <= idx + 1'b1;
            if (last) begin
                cout_reg <= chunk_cout;
                ovf_reg  <= (a_reg[DW-1] == b_reg[DW-1]) && (sum[CHUNK_W-1] != a_reg[DW-1]);
            end
        end
    end

    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Bench for wide_addsub_seq: 32-bit and 64-bit instances, table vectors with
// a done-time scoreboard, plus busy, reset-abort and ignored-start sequences.
module tb_wide_addsub_seq;

    typedef struct {
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t q2[$];
    exp_t q4[$];
    vec_t vecs[13];

    wide_addsub_seq_if #(.NUM_CHUNKS(2)) bus2 ();
    wide_addsub_seq_if #(.NUM_CHUNKS(4)) bus4 ();

    wide_addsub_seq #(.NUM_CHUNKS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    wide_addsub_seq #(.NUM_CHUNKS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected results are checked when done pulses, including the done cycle.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (bus2.done === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                chk("dut2 result", {32'b0, bus2.result}, e.res);
                chk("dut2 cout", {63'b0, bus2.cout}, {63'b0, e.cout});
                chk("dut2 ovf", {63'b0, bus2.ovf}, {63'b0, e.ovf});
                chk("dut2 done cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                chk("dut4 result", bus4.result, e.res);
                chk("dut4 cout", {63'b0, bus4.cout}, {63'b0, e.cout});
                chk("dut4 ovf", {63'b0, bus4.ovf}, {63'b0, e.ovf});
                chk("dut4 done cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic issue(input vec_t v, input bit track);
        int   n;
        exp_t e;
        n = 0;
        while (((v.wide ? bus4.ready : bus2.ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready wait timeout", 64'd0, 64'd1);
            return;
        end
        if (v.wide) begin
            bus4.op_a = v.a; bus4.op_b = v.b; bus4.sub = v.sub; bus4.start = 1'b1;
        end else begin
            bus2.op_a = v.a[31:0]; bus2.op_b = v.b[31:0]; bus2.sub = v.sub; bus2.start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        bus4.start = 1'b0;
        if (track) begin
            e.res  = v.res;
            e.cout = v.cout;
            e.ovf  = v.ovf;
            e.cyc  = cyc + (v.wide ? 4 : 2);
            if (v.wide) q4.push_back(e);
            else        q2.push_back(e);
        end
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while ((q2.size() != 0 || q4.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain timeout", 64'd0, 64'd1);
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.op_a = '0; bus2.op_b = '0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.op_a = '0; bus4.op_b = '0;

        vecs[0]  = '{1'b0, 64'h0000FFFF, 64'h00000001, 1'b0, 64'h00010000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 64'h00000000, 64'h00000001, 1'b1, 64'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 64'h00000005, 64'h00000003, 1'b1, 64'h00000002, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 64'h7FFFFFFF, 64'h00000001, 1'b0, 64'h80000000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 64'h80000000, 64'h00000001, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 64'hFFFFFFFF, 64'h00000001, 1'b0, 64'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 64'h12345678, 64'h9ABCDEF0, 1'b0, 64'hACF13568, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 64'h80000000, 64'h80000000, 1'b0, 64'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 64'h00000000, 64'h00000000, 1'b1, 64'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 64'h00001234, 64'h00005678, 1'b1, 64'hFFFFBBBC, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0000000000000000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 64'h0000000000000000, 64'h1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset ready", {63'b0, bus2.ready}, 64'd1);
        chk("reset busy", {63'b0, bus2.busy}, 64'd0);
        chk("reset done", {63'b0, bus2.done}, 64'd0);
        chk("reset result", {32'b0, bus2.result}, 64'd0);
        chk("reset cout/ovf", {62'b0, bus2.cout, bus2.ovf}, 64'd0);
        chk("reset result wide", bus4.result, 64'd0);
        chk("reset ready wide", {63'b0, bus4.ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Busy exactly for the two RUN cycles, then a single done cycle.
        issue(vecs[0], 1'b1);
        chk("busy t+1", {63'b0, bus2.busy}, 64'd1);
        chk("ready t+1", {63'b0, bus2.ready}, 64'd0);
        @(negedge clk);
        chk("busy t+2", {63'b0, bus2.busy}, 64'd1);
        @(negedge clk);
        chk("busy t+3", {63'b0, bus2.busy}, 64'd0);
        chk("done t+3", {63'b0, bus2.done}, 64'd1);
        @(negedge clk);
        chk("done t+4", {63'b0, bus2.done}, 64'd0);
        chk("result held in idle", {32'b0, bus2.result}, 64'h00010000);

        // Table run: consecutive issues land in the DONE cycle (back-to-back).
        for (int i = 0; i < 13; i++) issue(vecs[i], 1'b1);
        drain(3);

        // Start while busy must be ignored.
        issue(vecs[6], 1'b1);
        bus2.op_a = 32'h11111111; bus2.op_b = 32'h22222222; bus2.sub = 1'b1; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        drain(4);

        // Reset while running discards the operation.
        v = '{1'b0, 64'h0F0F0F0F, 64'h01010101, 1'b0, 64'h10101010, 1'b0, 1'b0};
        issue(v, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", {63'b0, bus2.ready}, 64'd1);
        chk("abort busy", {63'b0, bus2.busy}, 64'd0);
        chk("abort done", {63'b0, bus2.done}, 64'd0);
        chk("abort result", {32'b0, bus2.result}, 64'd0);
        chk("abort cout/ovf", {62'b0, bus2.cout, bus2.ovf}, 64'd0);
        repeat (6) @(negedge clk);
        issue(vecs[3], 1'b1);
        issue(vecs[11], 1'b1);
        drain(4);

        chk("scoreboard empty", 64'(q2.size() + q4.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wide_addsub_seq.md
Name: wide_addsub_seq

Overview:
Multi-cycle sequencer that performs DW-bit add/subtract (DW = 16*NUM_CHUNKS) using a single shared cla_16bit instance, one 16-bit chunk per cycle, LSB chunk first, rippling the carry through a register. It sits beside the execute stage for wide (32/48/64-bit) arithmetic, so the design needs no wider adder. The pipeline talks to it through a start/busy/done handshake.

Parameters:
NUM_CHUNKS, 2, number of 16-bit chunks; DW = 16*NUM_CHUNKS; legal range 2..4.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when ready=1
sub  input  1  0 = A+B, 1 = A-B; sampled with start
op_a  input  DW  operand A; sampled with start
op_b  input  DW  operand B; sampled with start
ready  output  1  high in IDLE and DONE; start accepted
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result/cout/ovf valid
result  output  DW  sum/difference; held until the next accepted start
cout  output  1  final carry out; for sub, 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- States: IDLE, RUN, DONE. Reset (any state, including mid-RUN): state=IDLE; result=0, cout=0, ovf=0, done=0, busy=0, ready=1. The internal chunk index and carry register clear to 0. Any operation in flight is discarded with no done pulse.
- IDLE: if start=1, latch op_a into a_reg and (sub ? ~op_b : op_b) into b_reg. Set carry_reg=sub, idx=0, state=RUN. Otherwise stay in IDLE.
- RUN: adder inputs are a_reg[16*idx +: 16], b_reg[16*idx +: 16], Cin=carry_reg. On each edge:
  - result[16*idx +: 16] <= S
  - carry_reg <= Cout
  - idx <= idx+1
- When idx == NUM_CHUNKS-1, that edge also:
  - sets cout <= Cout
  - sets ovf <= (a_reg[DW-1] == b_reg[DW-1]) && (S[15] != a_reg[DW-1]), using the inverted b for sub
  - moves state to DONE
- DONE: done=1 for exactly one cycle, then IDLE. If start=1 in DONE, the new operation is latched as in IDLE and state goes straight to RUN (back-to-back, no idle bubble).
- Latency: start accepted at cycle t gives RUN in cycles t+1..t+NUM_CHUNKS and done=1 in cycle t+NUM_CHUNKS+1. Throughput is one operation per NUM_CHUNKS+1 cycles.
- start while busy=1 is ignored. No queuing; operands and sub are not re-sampled.
- result chunks not yet written during RUN keep their prior values. Consumers use result only when done=1 or in IDLE after done.
- The adder is purely combinational. Only the registers above hold state, and no output depends combinationally on start.
- Wrap-around: result is modulo 2^DW. The carry out of the top chunk goes only to cout.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), CHUNK_W=16, and the index width derived from NUM_CHUNKS.
- One sub-module: a single cla_16bit instance as the chunk adder. No other sub-modules; FSM and datapath registers live in wide_addsub_seq.

Test Plan:
- NUM_CHUNKS=2, start at t with op_a=0x0000FFFF, op_b=0x00000001, sub=0: done=1 at t+3, result=0x00010000, cout=0, ovf=0; busy=1 exactly at t+1, t+2.
- Subtraction: op_a=0x00000000, op_b=0x00000001, sub=1: result=0xFFFFFFFF, cout=0, ovf=0. Then op_a=5, op_b=3, sub=1: result=0x00000002, cout=1.
- Signed overflow: 0x7FFFFFFF + 0x00000001 gives result=0x80000000, ovf=1, cout=0. Then 0x80000000 - 0x00000001 gives result=0x7FFFFFFF, ovf=1, cout=1.
- Start while busy: second start with different operands at t+1 is ignored. done occurs only once, at t+3, with the first operation's result.
- Reset mid-op: rst=1 at t+1. Next cycle: IDLE, ready=1, result=0, no done pulse ever appears for that operation. A fresh start then completes normally.
- Back-to-back: start held during the DONE cycle (t+3) with 0xFFFFFFFF+0x00000001 gives done at t+6, result=0x00000000, cout=1, ovf=0. Repeat with NUM_CHUNKS=4: done at start+5.
